control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multi-cycle accumulator control FSM: fetch/decode/exec/mem
// sequencing with a memory-request watchdog.
module control_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       mem_ack,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_src,
  output logic       illegal,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     st;
  logic [7:0] opc;
  logic [7:0] wcnt;
  logic       fault_q;
  logic [3:0] op;

  logic is_nop, is_lda, is_sta, is_alu;
  logic is_jmp, is_jz, is_hlt, is_ill;

  logic unused_operand;

  assign op = opc[7:4];
  assign unused_operand = ^opc[3:0];

  always_comb begin
    is_nop = 1'b0;
    is_lda = 1'b0;
    is_sta = 1'b0;
    is_alu = 1'b0;
    is_jmp = 1'b0;
    is_jz  = 1'b0;
    is_hlt = 1'b0;
    is_ill = 1'b0;
    unique case (1'b1)
      op == 4'h0:             is_nop = 1'b1;
      op == 4'h1:             is_lda = 1'b1;
      op == 4'h2:             is_sta = 1'b1;
      op >= 4'h3 && op <= 4'h6: is_alu = 1'b1;
      op == 4'h7:             is_jmp = 1'b1;
      op == 4'h8:             is_jz  = 1'b1;
      op == 4'hF:             is_hlt = 1'b1;
      default:                is_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      opc     <= 8'h00;
      wcnt    <= 8'h00;
      fault_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          st   <= FETCH;
          wcnt <= 8'h00;
        end
        FETCH, MEM: begin
          if (mem_ack) begin
            if (st == FETCH) begin
              opc <= instr;
              st  <= DECODE;
            end else begin
              st  <= FETCH;
            end
            wcnt <= 8'h00;
          end else if (wcnt == WAIT_LAST) begin
            st      <= HALT;
            fault_q <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        DECODE: begin
          wcnt <= 8'h00;
          unique case (1'b1)
            is_nop || is_ill:         st <= FETCH;
            is_lda || is_sta:         st <= MEM;
            is_alu || is_jmp || is_jz: st <= EXEC;
            default:                  st <= HALT;
          endcase
        end
        EXEC: begin
          st   <= FETCH;
          wcnt <= 8'h00;
        end
        HALT: st <= HALT;
        default: begin
          st   <= IDLE;
          wcnt <= 8'h00;
        end
      endcase
    end
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    alu_op  = 2'd0;
    reg_we  = 1'b0;
    reg_src = 1'b0;
    illegal = 1'b0;
    halted  = 1'b0;
    if (!rst) begin
      unique case (st)
        FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ack;
          pc_inc  = mem_ack;
        end
        DECODE: illegal = is_ill;
        EXEC: begin
          if (is_alu) begin
            reg_we = 1'b1;
            // op-3 folded into two bits
            alu_op = op[1:0] + 2'd1;
          end
          if (is_jmp) pc_load = 1'b1;
          if (is_jz)  pc_load = zero;
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = is_sta;
          reg_we  = is_lda & mem_ack;
          reg_src = is_lda & mem_ack;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign fault = fault_q & ~rst;
  assign state = rst ? 3'd0 : 3'(st);

endmodule
